// File: rtl/stack_ctrl_pkg.sv
// Shared types and default parameters for the PC/flags return-stack sequencer.
package stack_ctrl_pkg;

    localparam int unsigned PC_W_DEF    = 9;
    localparam int unsigned FLAGS_W_DEF = 4;
    localparam int unsigned DEPTH_DEF   = 5;
    localparam int unsigned DEPTH_W_DEF = 3;
    localparam logic [8:0]  IRQ_VECTOR_DEF = 9'h100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_LOAD,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_CALL,
        OP_RET,
        OP_RETI,
        OP_IRQ
    } op_t;

endpackage

// File: rtl/stack_depth_tracker.sv
// Saturating stack-depth counter with sticky overflow/underflow flags.
module stack_depth_tracker
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               underflow_evt,
    input  logic               clr_err,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    always_comb begin
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push && (depth_q != DEPTH_MAX)) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && (depth_q != '0)) begin
            depth_d = depth_q - DEPTH_W'(1);
        end

        // Clear first so a same-cycle error event keeps the flag set.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push && (depth_q == DEPTH_MAX)) begin
            overflow_d = 1'b1;
        end
        if (underflow_evt) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/stack_seq_ctrl.sv
// Return-stack sequencer: arbitrates CALL/RET/RETI/IRQ, drives stack strobes and PC/flags loads.
module stack_seq_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W       = PC_W_DEF,
    parameter int unsigned     FLAGS_W    = FLAGS_W_DEF,
    parameter int unsigned     DEPTH      = DEPTH_DEF,
    parameter int unsigned     DEPTH_W    = DEPTH_W_DEF,
    parameter logic [PC_W-1:0] IRQ_VECTOR = IRQ_VECTOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic               reti_req,
    input  logic               irq,
    input  logic               irq_enable,
    input  logic               clr_err,
    input  logic [PC_W-1:0]    cur_pc,
    input  logic [PC_W-1:0]    call_target,
    input  logic [FLAGS_W-1:0] cur_flags,
    output logic               stk_push_en,
    output logic               stk_pop_en,
    output logic [PC_W-1:0]    stk_in_pc,
    output logic [FLAGS_W-1:0] stk_in_flags,
    input  logic [PC_W-1:0]    stk_out_pc,
    input  logic [FLAGS_W-1:0] stk_out_flags,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_next,
    output logic               flags_load,
    output logic [FLAGS_W-1:0] flags_next,
    output logic               done,
    output logic               irq_ack,
    output logic               busy,
    output logic               in_isr,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [PC_W-1:0]    push_pc_q, push_pc_d;
    logic [PC_W-1:0]    tgt_q, tgt_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               in_isr_q, in_isr_d;

    // Next state, operand capture and ISR tracking.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        push_pc_d = push_pc_q;
        tgt_d     = tgt_q;
        flags_d   = flags_q;
        in_isr_d  = in_isr_q;

        case (state_q)
            ST_IDLE: begin
                if (irq && irq_enable && !in_isr_q) begin
                    // Push cur_pc-1 because the stack returns pushed+1.
                    op_d      = OP_IRQ;
                    push_pc_d = cur_pc - PC_W'(1);
                    tgt_d     = IRQ_VECTOR;
                    flags_d   = cur_flags;
                    state_d   = ST_PUSH;
                end else if (reti_req) begin
                    op_d    = OP_RETI;
                    state_d = (depth == '0) ? ST_ERR : ST_POP;
                end else if (ret_req) begin
                    op_d    = OP_RET;
                    state_d = (depth == '0) ? ST_ERR : ST_POP;
                end else if (call_req) begin
                    op_d      = OP_CALL;
                    push_pc_d = cur_pc;
                    tgt_d     = call_target;
                    flags_d   = cur_flags;
                    state_d   = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (op_q == OP_IRQ) begin
                    in_isr_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (op_q == OP_RETI) begin
                    in_isr_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; every output is zero in IDLE.
    always_comb begin
        stk_push_en  = 1'b0;
        stk_pop_en   = 1'b0;
        stk_in_pc    = '0;
        stk_in_flags = '0;
        pc_load      = 1'b0;
        pc_next      = '0;
        flags_load   = 1'b0;
        flags_next   = '0;
        done         = 1'b0;
        irq_ack      = 1'b0;

        case (state_q)
            ST_PUSH: begin
                stk_push_en  = 1'b1;
                stk_in_pc    = push_pc_q;
                stk_in_flags = flags_q;
                pc_load      = 1'b1;
                pc_next      = tgt_q;
                if (op_q == OP_IRQ) begin
                    irq_ack = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
            ST_POP: begin
                stk_pop_en = 1'b1;
            end
            ST_LOAD: begin
                pc_load = 1'b1;
                pc_next = stk_out_pc;
                done    = 1'b1;
                if (op_q == OP_RETI) begin
                    flags_load = 1'b1;
                    flags_next = stk_out_flags;
                end
            end
            ST_ERR: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_CALL;
            push_pc_q <= '0;
            tgt_q     <= '0;
            flags_q   <= '0;
            in_isr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            push_pc_q <= push_pc_d;
            tgt_q     <= tgt_d;
            flags_q   <= flags_d;
            in_isr_q  <= in_isr_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign in_isr = in_isr_q;

    stack_depth_tracker #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk           (clk),
        .reset         (reset),
        .push          (state_q == ST_PUSH),
        .pop           (state_q == ST_POP),
        .underflow_evt (state_q == ST_ERR),
        .clr_err       (clr_err),
        .depth         (depth),
        .overflow      (overflow),
        .underflow     (underflow)
    );

endmodule
